pe_dot_sequencer: RTL and testbench
===================================

Name: pe_dot_sequencer

Overview:
Sequences a single PE (registered activation/weight/psum inputs, registered psum output, two-cycle input-to-output latency, no enable) to compute one dot product of configurable length.
- Accepts (activation, weight) pairs over a valid/ready stream.
- Issues each pair to the PE together with the running sum.
- Recirculates the PE output through an internal accumulator and returns the final sum on a valid/ready result port.
- Sits between the operand fetch logic and one PE instance. The PE is instantiated outside this block.

Parameters:
ACT_W, 8, activation/weight width (PE weight parallelism)
ACC_W, 32, partial-sum width (PE accumulation parallelism)
LEN_W, 16, width of the dot-product length field

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a dot product; sampled only in IDLE
cfg_len  in  LEN_W  number of pairs; sampled with start
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid & in_ready
in_act  in  ACT_W  activation
in_weight  in  ACT_W  weight
pe_activation  out  ACT_W  to PE activation input
pe_weight  out  ACT_W  to PE weight input
pe_psum_in  out  ACC_W  to PE input partial sum
pe_psum_out  in  ACC_W  from PE output partial sum
res_valid  out  1  result valid, held until accepted
res_ready  in  1  result consumer ready
res_data  out  ACC_W  final dot product

Behaviour:
- Reset: synchronous and active-high; rst=1 at a rising edge forces the following.
  - State: IDLE.
  - Registers cleared: remaining count, acc, issue pipe, res_data.
  - Outputs: busy=0, in_ready=0, res_valid=0, res_data=0, pe_* driven 0.
  - Reset mid-operation abandons the operation. Pairs already inside the PE are ignored; the issue pipe is cleared.
- States: IDLE, ISSUE, WAIT, DRAIN, RESULT.
- IDLE:
  - start=1 with cfg_len>0: acc<=0, rem<=cfg_len, go to ISSUE.
  - start=1 with cfg_len=0: res_data<=0, go to RESULT.
- ISSUE:
  - in_ready=1.
  - On handshake, drive pe_activation=in_act, pe_weight=in_weight, pe_psum_in=psum_sel, and set issue_d[0]; rem<=rem-1.
  - Next state is DRAIN if rem==1, else WAIT.
  - Without handshake, stay in ISSUE. Stalls of any length are legal.
- WAIT: one cycle, in_ready=0; then ISSUE. This enforces the minimum issue spacing of 2 cycles, equal to the PE latency.
- Issue pipe: issue_d shifts every cycle (issue_d[1]<=issue_d[0]).
  - When issue_d[1]=1, pe_psum_out is the valid sum of the pair issued 2 cycles earlier, and acc<=pe_psum_out.
  - psum_sel = issue_d[1] ? pe_psum_out : acc. This bypass allows back-to-back issue at cycle c+2 after an issue at cycle c.
- Non-issue cycles: pe_activation=0, pe_weight=0, pe_psum_in=0. The product is zero, so the PE's sign-magnitude carry_in stays 0. PE outputs produced from these cycles are never consumed.
- DRAIN:
  - Wait until issue_d[1]=1.
  - Then res_data<=pe_psum_out and go to RESULT.
- RESULT:
  - res_valid=1, res_data stable.
  - On res_valid & res_ready, go to IDLE.
  - A start in the same cycle is ignored; start is accepted from IDLE only.
- Latency: start accepted in cycle s, N pairs, no stalls.
  - Issues occur at s+1, s+3, …, s+2N-1.
  - res_valid rises at s+2N+2.
  - With cfg_len=0, res_valid rises at s+1.
- Arithmetic: performed entirely by the PE; the sum wraps modulo 2^ACC_W. The sequencer never modifies sum values.
- start while busy: ignored. cfg_len is not re-sampled.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - state enum seq_state_t (IDLE, ISSUE, WAIT, DRAIN, RESULT);
  - localparam PE_LATENCY=2, used to size issue_d and the WAIT spacing.
- No sub-module. Reuse the existing register block for res_data only if its clear/sample_en semantics match synchronous active-high reset; otherwise code it inline.

Test Plan:
- Bench with a PE instance, len=3, pairs (1,2),(3,4),(5,6), in_valid always 1 -> in_ready pulses at s+1,s+3,s+5; res_data=44, res_valid at s+8, held until res_ready.
- Same vectors with in_valid low for 4 cycles before the 2nd pair -> res_data=44; pe_psum_in of the 2nd issue equals acc=2.
- cfg_len=0 -> res_valid at s+1, res_data=0; no in_ready pulse.
- rst=1 during WAIT of a len=4 run, then a new len=1 run with (7,7) -> res_data=49; no residue from the aborted run.
- start pulsed while busy, and again in the same cycle as the result handshake -> both ignored; busy drops for exactly one cycle before a later start is accepted.
- Len=2 with sums crossing 2^ACC_W (ACC_W=16, pre-loaded large products) -> res_data wraps modulo 2^16.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: sequencer state type and PE pipeline timing shared by the
// dot-product control logic.
package pe_ctrl_pkg;
    localparam int PE_LATENCY = 2;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESULT} seq_state_t;
endpackage

// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: feeds (activation, weight) pairs to one external PE, recirculating
// its registered partial sum, and returns the finished dot product on a valid/ready port.
module pe_dot_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int ACT_W = 8,
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACT_W-1:0] in_act,
    input  logic [ACT_W-1:0] in_weight,
    output logic [ACT_W-1:0] pe_activation,
    output logic [ACT_W-1:0] pe_weight,
    output logic [ACC_W-1:0] pe_psum_in,
    input  logic [ACC_W-1:0] pe_psum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);
    seq_state_t state, state_n;
    logic [LEN_W-1:0] rem;
    logic [ACC_W-1:0] acc, psum_sel;
    logic [PE_LATENCY-1:0] issue_d;
    logic fire, sum_ok;

    assign busy      = state != IDLE;
    assign in_ready  = state == ISSUE;
    assign res_valid = state == RESULT;
    assign fire      = in_valid && in_ready;
    assign sum_ok    = issue_d[PE_LATENCY-1];
    // Bypass lets an issue land in the same cycle its predecessor's sum emerges.
    assign psum_sel  = sum_ok ? pe_psum_out : acc;
    // Idle cycles feed zeros so the PE's stale outputs stay harmless.
    assign pe_activation = fire ? in_act : '0;
    assign pe_weight     = fire ? in_weight : '0;
    assign pe_psum_in    = fire ? psum_sel : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !start ? IDLE : (cfg_len == '0) ? RESULT : ISSUE;
            ISSUE:   state_n = !fire ? ISSUE : (rem == LEN_W'(1)) ? DRAIN : WAIT;
            WAIT:    state_n = ISSUE;
            DRAIN:   state_n = sum_ok ? RESULT : DRAIN;
            RESULT:  state_n = res_ready ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            acc      <= '0;
            issue_d  <= '0;
            res_data <= '0;
        end else begin
            state   <= state_n;
            issue_d <= {issue_d[PE_LATENCY-2:0], fire};
            if (state == IDLE && start) begin
                acc <= '0;
                rem <= cfg_len;
                if (cfg_len == '0)
                    res_data <= '0;
            end else if (sum_ok) begin
                acc <= pe_psum_out;
            end
            if (fire)
                rem <= rem - LEN_W'(1);
            if (state == DRAIN && sum_ok)
                res_data <= pe_psum_out;
        end
    end
endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: drives pe_dot_sequencer with a behavioural PE and checks it
// against a running-sum model of the dot product plus hand-computed expectations.
module tb_pe_dot_sequencer;
    localparam int ACT_W = 8;
    localparam int ACC_W = 16;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ACT_W-1:0] in_act = '0;
    logic [ACT_W-1:0] in_weight = '0;
    logic [ACT_W-1:0] pe_activation, pe_weight;
    logic [ACC_W-1:0] pe_psum_in;
    logic [ACC_W-1:0] pe_psum_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_data;

    always #5 clk = ~clk;

    pe_dot_sequencer #(.ACT_W(ACT_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
        .pe_activation(pe_activation), .pe_weight(pe_weight), .pe_psum_in(pe_psum_in),
        .pe_psum_out(pe_psum_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    // Behavioural PE: registered inputs, registered output, two-cycle latency.
    logic [ACT_W-1:0] a_r = '0, w_r = '0;
    logic [ACC_W-1:0] p_r = '0;
    always @(posedge clk) begin
        a_r <= pe_activation;
        w_r <= pe_weight;
        p_r <= pe_psum_in;
        pe_psum_out <= p_r + ACC_W'(a_r) * ACC_W'(w_r);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model of the current run: sum of products of every accepted pair so far.
    logic [ACC_W-1:0] m_sum = '0;
    int m_cnt = 0, m_len = 0, s_cyc = 0, rv_cyc = -1;
    logic prev_fire = 1'b0, prev_rv = 1'b0;
    int hs_cyc[$];
    logic [ACC_W-1:0] hs_psum[$];

    always @(negedge clk) begin
        if (rst) begin
            prev_fire = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (start && !busy) begin
                m_sum = '0;
                m_cnt = 0;
                m_len = int'(cfg_len);
                s_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                chk("issue_act", 32'(pe_activation), 32'(in_act));
                chk("issue_wt", 32'(pe_weight), 32'(in_weight));
                chk("issue_psum", 32'(pe_psum_in), 32'(m_sum));
                chk("issue_spacing", 32'(prev_fire), 0);
                chk("issue_count", 32'(m_cnt < m_len), 1);
                hs_cyc.push_back(cyc);
                hs_psum.push_back(pe_psum_in);
                m_sum = m_sum + ACC_W'(in_act) * ACC_W'(in_weight);
                m_cnt++;
            end else begin
                chk("idle_pe_zero", {pe_activation, pe_weight, pe_psum_in}, 0);
            end
            if (res_valid) begin
                chk("res_data_model", 32'(res_data), 32'(m_sum));
                chk("res_pair_count", m_cnt, m_len);
                if (!prev_rv) rv_cyc = cyc;
            end
            if (!busy) chk("idle_flags", {30'd0, in_ready, res_valid}, 0);
            prev_fire = in_valid && in_ready;
            prev_rv = res_valid;
        end
    end

    logic [ACT_W-1:0] va[8], vw[8];

    // Called at posedge+1: the current cycle becomes the start cycle s.
    task automatic do_start(input int len);
        hs_cyc.delete();
        hs_psum.delete();
        rv_cyc = -1;
        start = 1'b1;
        cfg_len = LEN_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_len = '0;
    endtask

    task automatic feed(input int n, input int stall_idx, input int stall_n);
        int i = 0, t = 0, s = stall_n;
        while (i < n && t < 200) begin
            if (i == stall_idx && s > 0) begin
                in_valid = 1'b0;
                repeat (s) @(posedge clk);
                #1;
                s = 0;
            end
            in_valid = 1'b1;
            in_act = va[i];
            in_weight = vw[i];
            @(negedge clk);
            if (in_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        in_act = '0;
        in_weight = '0;
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic get_result(input int hold, input bit start_on_ack, output logic [ACC_W-1:0] d);
        int t = 0;
        while (!res_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("res_wait", 32'(res_valid), 1);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("res_held", 32'(res_valid), 1);
        end
        d = res_data;
        res_ready = 1'b1;
        if (start_on_ack) begin
            start = 1'b1;
            cfg_len = LEN_W'(3);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        start = 1'b0;
        cfg_len = '0;
    endtask

    logic [ACC_W-1:0] d, exp_sum;
    int len, stall_idx, stall_n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // len=3: 1*2 + 3*4 + 5*6 = 44, issues at s+1,s+3,s+5, result at s+8
        va[0] = 1; vw[0] = 2; va[1] = 3; vw[1] = 4; va[2] = 5; vw[2] = 6;
        do_start(3);
        feed(3, -1, 0);
        get_result(3, 1'b0, d);
        chk("t1_sum", 32'(d), 44);
        chk("t1_issues", hs_cyc.size(), 3);
        for (int k = 0; k < hs_cyc.size(); k++) chk("t1_issue_cycle", hs_cyc[k], s_cyc + 1 + 2 * k);
        chk("t1_res_cycle", rv_cyc, s_cyc + 8);
        chk("t1_idle_after", 32'(busy), 0);

        // same vectors, 4 stall cycles before the 2nd pair
        do_start(3);
        feed(3, 1, 4);
        get_result(1, 1'b0, d);
        chk("t2_sum", 32'(d), 44);
        chk("t2_issues", hs_psum.size(), 3);
        chk("t2_psum2", 32'(hs_psum[1]), 2);

        // zero-length: result the cycle after start, no issue
        do_start(0);
        get_result(0, 1'b0, d);
        chk("t3_sum", 32'(d), 0);
        chk("t3_res_cycle", rv_cyc, s_cyc + 1);
        chk("t3_no_issue", hs_cyc.size(), 0);

        // reset in WAIT of a len=4 run, then len=1 with (7,7)
        va[0] = 9; vw[0] = 9;
        do_start(4);
        feed(1, -1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_res_data", 32'(res_data), 0);
        va[0] = 7; vw[0] = 7;
        do_start(1);
        feed(1, -1, 0);
        get_result(0, 1'b0, d);
        chk("t4_sum", 32'(d), 49);

        // start while busy and with the result handshake: both ignored
        va[0] = 2; vw[0] = 3; va[1] = 4; vw[1] = 5;
        do_start(2);
        fork
            feed(2, -1, 0);
            begin
                start = 1'b1;
                cfg_len = LEN_W'(6);
                @(posedge clk); #1;
                start = 1'b0;
                cfg_len = '0;
            end
        join
        get_result(0, 1'b1, d);
        chk("t5_sum", 32'(d), 26);
        chk("t5_idle_gap", 32'(busy), 0);
        va[0] = 1; vw[0] = 1;
        do_start(1);
        chk("t5_restart_busy", 32'(busy), 1);
        feed(1, -1, 0);
        get_result(0, 1'b0, d);
        chk("t5_restart_sum", 32'(d), 1);

        // wrap: 2*255*255 = 130050 mod 65536 = 64514
        va[0] = 255; vw[0] = 255; va[1] = 255; vw[1] = 255;
        do_start(2);
        feed(2, -1, 0);
        get_result(0, 1'b0, d);
        chk("t6_wrap", 32'(d), 64514);

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 8);
            exp_sum = '0;
            for (int i = 0; i < len; i++) begin
                va[i] = ACT_W'($urandom_range(0, 255));
                vw[i] = ACT_W'($urandom_range(0, 255));
                exp_sum = exp_sum + ACC_W'(va[i]) * ACC_W'(vw[i]);
            end
            stall_idx = $urandom_range(0, 1) ? $urandom_range(0, len - 1) : -1;
            stall_n = $urandom_range(1, 5);
            do_start(len);
            feed(len, stall_idx, stall_n);
            get_result($urandom_range(0, 3), 1'b0, d);
            chk("rand_sum", 32'(d), 32'(exp_sum));
            if (stall_idx < 0) chk("rand_latency", rv_cyc, s_cyc + 2 * len + 2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
